pll_lock_supervisor: RTL

//   Consumer side of the PLL lock interface. Drives the PLL active-high reset and

---
 rtl/pll_lock_supervisor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the PLL reset and gates the system reset on a stable PLL lock.
//   It runs on the free-running reference clock and never on the PLL output.
//   A lock timeout or a loss of lock in RUN triggers a fresh PLL reset.
//   A lock glitch during STABLE only restarts the wait for lock.
//
// Parameters
//   RST_CYCLES     cycles pll_reset is held high per reset attempt (>=1)
//   LOCK_TIMEOUT   cycles to wait for extlock before re-resetting the PLL (>=1)
//   STABLE_CYCLES  cycles extlock must stay high before release (>=1)
//   CNT_W          counter width; must hold max(all three params)-1
//
// Ports
//   clk         in   reference clock
//   rst_n       in   asynchronous active-low reset
//   extlock     in   PLL lock flag, asynchronous to clk
//   pll_reset   out  active-high reset to the PLL
//   sys_rst_n   out  active-low system reset, released only in RUN
//   locked      out  high only in RUN
//   state_o     out  current state (0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN)
//   relock_cnt  out  saturating count of recovery events
//
// State      | meaning
// -----------+-----------------------------------------------------------
// RESET      | PLL held in reset for RST_CYCLES cycles
// WAIT_LOCK  | PLL released; waiting up to LOCK_TIMEOUT cycles for lock
// STABLE     | lock seen; it must hold for STABLE_CYCLES cycles
// RUN        | system reset released; any loss of lock re-resets the PLL

module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 24000,
    parameter int STABLE_CYCLES = 240,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [1:0] state_o,
    output logic [7:0] relock_cnt
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             relock_inc;
    logic             lock_meta;
    logic             lock_s;

    // extlock comes from the PLL domain; only the second flop is used by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= extlock;
            lock_s    <= lock_meta;
        end
    end

    // State, counter and registered outputs. The outputs are decoded from the
    // next state so that they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            pll_reset <= (state_nxt == ST_RESET);
            sys_rst_n <= (state_nxt == ST_RUN);
            locked    <= (state_nxt == ST_RUN);
            if (relock_inc && (relock_cnt != 8'hFF)) begin
                relock_cnt <= relock_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q + CNT_W'(1);
        relock_inc = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout edge still counts as a lock.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_nxt  = ST_RESET;
                    cnt_nxt    = '0;
                    relock_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                // A glitch here only restarts the wait; the PLL is not reset.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt_q;
                if (!lock_s) begin
                    state_nxt  = ST_RESET;
                    cnt_nxt    = '0;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign state_o = state_q;

endmodule
